// File: rtl/conv_encoder.sv
// conv_encoder
// Rate-1/2 feedforward convolutional encoder. Each accepted input bit yields
// one 2-bit code symbol {G0 parity, G1 parity} through a single registered
// output stage with ready/valid handshakes on both sides.
//
// Optional feature (compile-time macro CONV_ENC_TAIL_EN):
//   defined   : after the in_last bit, K-1 zero tail symbols are emitted so the
//               trellis terminates in state 0; out_last marks the final tail
//               symbol and input is stalled during the tail.
//   undefined : no tail; out_last marks the symbol of the in_last bit and the
//               shift register is cleared when that bit is accepted.
//
// Handshake semantics (both ports): a transfer happens on a rising clk edge
// where valid and ready are both high. A producer holding valid high keeps its
// payload stable until the transfer; ready may depend combinationally on the
// consumer side (in_ready depends on out_ready), never on in_valid.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   in_valid/in_ready     input handshake; in_bit data, in_last frame end
//   out_valid/out_ready   output handshake; out_sym symbol, out_last frame end
//   busy                  tail in progress or a symbol is waiting in the output
//
// K must be at least 3 (the shift register update slices sr[K-2:1]).

module conv_encoder #(
  parameter int           K  = 3,
  parameter logic [K-1:0] G0 = 3'b111,
  parameter logic [K-1:0] G1 = 3'b101
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic       in_bit,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [1:0] out_sym,
  output logic       out_last,
  output logic       busy
);

  // Window is {current bit, sr}; sr[K-2] is the most recent previous bit.
  function automatic logic [1:0] encode(input logic b, input logic [K-2:0] s);
    logic [K-1:0] w;
    w      = {b, s};
    encode = {^(w & G0), ^(w & G1)};
  endfunction

  logic [K-2:0] sr_q, sr_d;
  logic         out_valid_q, out_valid_d;
  logic [1:0]   out_sym_q, out_sym_d;
  logic         out_last_q, out_last_d;
  logic         slot_free;
  logic         load;
  logic         load_bit;

`ifdef CONV_ENC_TAIL_EN
  localparam int TCW = (K > 2) ? $clog2(K - 1) : 1;
  localparam logic [TCW-1:0] TAIL_LAST = TCW'(K - 2);

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_TAIL = 1'b1
  } state_t;

  state_t         state_q, state_d;
  logic [TCW-1:0] tcnt_q, tcnt_d;
`endif

  always_comb begin
    slot_free   = !out_valid_q || out_ready;
    load        = 1'b0;
    load_bit    = 1'b0;
    in_ready    = 1'b0;
    out_sym_d   = out_sym_q;
    out_last_d  = out_last_q;
    sr_d        = sr_q;
`ifdef CONV_ENC_TAIL_EN
    state_d     = state_q;
    tcnt_d      = tcnt_q;
    case (state_q)
      ST_RUN: begin
        in_ready = slot_free;
        if (in_valid && slot_free) begin
          load       = 1'b1;
          load_bit   = in_bit;
          out_last_d = 1'b0;
          if (in_last) begin
            state_d = ST_TAIL;
            tcnt_d  = '0;
          end
        end
      end
      ST_TAIL: begin
        // Tail symbols are encodings of zero bits; the last one flushes sr.
        if (slot_free) begin
          load     = 1'b1;
          load_bit = 1'b0;
          if (tcnt_q == TAIL_LAST) begin
            out_last_d = 1'b1;
            state_d    = ST_RUN;
            tcnt_d     = '0;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
`else
    in_ready = slot_free;
    if (in_valid && slot_free) begin
      load       = 1'b1;
      load_bit   = in_bit;
      out_last_d = in_last;
    end
`endif

    if (load) begin
      out_sym_d = encode(load_bit, sr_q);
      sr_d      = {load_bit, sr_q[K-2:1]};
    end

`ifndef CONV_ENC_TAIL_EN
    // Without a tail, the next frame must still start from state 0.
    if (load && in_last) begin
      sr_d = '0;
    end
`endif

    if (load) begin
      out_valid_d = 1'b1;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sr_q        <= '0;
      out_valid_q <= 1'b0;
      out_sym_q   <= 2'b00;
      out_last_q  <= 1'b0;
`ifdef CONV_ENC_TAIL_EN
      state_q     <= ST_RUN;
      tcnt_q      <= '0;
`endif
    end else begin
      sr_q        <= sr_d;
      out_valid_q <= out_valid_d;
      out_sym_q   <= out_sym_d;
      out_last_q  <= out_last_d;
`ifdef CONV_ENC_TAIL_EN
      state_q     <= state_d;
      tcnt_q      <= tcnt_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_sym   = out_sym_q;
  assign out_last  = out_last_q;
`ifdef CONV_ENC_TAIL_EN
  assign busy      = (state_q == ST_TAIL) || out_valid_q;
`else
  assign busy      = out_valid_q;
`endif

endmodule

// File: tb/tb_conv_encoder.sv
// tb_conv_encoder
// Bench for conv_encoder (K=3, G0=111, G1=101). Works with or without
// CONV_ENC_TAIL_EN; expected sequences follow the build.

module tb_conv_encoder;

`ifdef CONV_ENC_TAIL_EN
  localparam bit TAIL_ON = 1'b1;
`else
  localparam bit TAIL_ON = 1'b0;
`endif

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_last;
  logic       out_valid;
  logic       out_ready;
  logic [1:0] out_sym;
  logic       out_last;
  logic       busy;

  conv_encoder dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sym   (out_sym),
    .out_last  (out_last),
    .busy      (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Entries are {last, sym}.
  logic [2:0] exp_q[$];
  logic [2:0] obs_q[$];
  logic [2:0] ref_q[$];
  int         obs_cyc[$];
  int         last_cnt = 0;
  logic       p1 = 1'b0;  // most recent previous bit
  logic       p2 = 1'b0;  // bit before that

  // Reference encoder written directly from the generators:
  // G0=111 -> b^p1^p2, G1=101 -> b^p2.
  task automatic model_push(input logic b, input logic l);
    logic [1:0] s;
    s = {b ^ p1 ^ p2, b ^ p2};
    p2 = p1;
    p1 = b;
    if (TAIL_ON) begin
      exp_q.push_back({1'b0, s});
      if (l) begin
        for (int i = 0; i < 2; i++) begin
          s = {p1 ^ p2, p2};
          p2 = p1;
          p1 = 1'b0;
          exp_q.push_back({(i == 1), s});
        end
      end
    end else begin
      exp_q.push_back({l, s});
      if (l) begin
        p1 = 1'b0;
        p2 = 1'b0;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      p1 = 1'b0;
      p2 = 1'b0;
    end else begin
      // Anything still expected is either in the output register or a pending tail.
      check("busy", busy, exp_q.size() != 0);
      if (out_valid && out_ready) begin
        obs_q.push_back({out_last, out_sym});
        obs_cyc.push_back(cyc);
        if (out_last) last_cnt++;
        if (exp_q.size() == 0) begin
          check("sb_unexpected", {out_last, out_sym}, 32'hDEAD);
        end else begin
          check("sb_sym", {out_last, out_sym}, exp_q.pop_front());
        end
      end
      if (in_valid && in_ready) model_push(in_bit, in_last);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_bit(input logic b, input logic l);
    in_valid = 1'b1;
    in_bit   = b;
    in_last  = l;
    for (int t = 0; ; t++) begin
      @(negedge clk);
      if (in_ready) break;
      if (t > 300) begin
        check("send_timeout", 1, 0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_bit   = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; ; t++) begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0 && !out_valid) break;
      if (t > 500) begin
        check("drain_timeout", 0, 1);
        break;
      end
    end
  endtask

  task automatic check_obs(input string tag);
    check({tag, "_count"}, obs_q.size(), ref_q.size());
    for (int i = 0; i < ref_q.size() && i < obs_q.size(); i++) begin
      check(tag, obs_q[i], ref_q[i]);
    end
  endtask

  task automatic clear_obs();
    obs_q.delete();
    obs_cyc.delete();
  endtask

  // ---------------- stimulus ----------------
  logic t5_done;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    out_ready = 1'b1;
    t5_done   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sym", out_sym, 2'b00);
    check("rst_out_last", out_last, 0);
    check("rst_busy", busy, 0);
    check("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    // Test 1: frame 1,0,1 with out_ready high
    clear_obs();
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t1_in_ready", in_ready, (TAIL_ON && i < 2) ? 1'b0 : 1'b1);
    end
    drain();
    if (TAIL_ON) ref_q = '{3'b011, 3'b010, 3'b000, 3'b010, 3'b111};
    else         ref_q = '{3'b011, 3'b010, 3'b100};
    check_obs("t1_seq");
    check("t1_span", obs_cyc[obs_cyc.size()-1] - obs_cyc[0], ref_q.size() - 1);
    check("t1_busy_idle", busy, 0);

    // Test 2: frame 1,1 then immediately frame 1
    @(posedge clk);
    #1;
    clear_obs();
    send_bit(1'b1, 1'b0);
    send_bit(1'b1, 1'b1);
    send_bit(1'b1, 1'b1);
    drain();
    if (TAIL_ON) ref_q = '{3'b011, 3'b001, 3'b001, 3'b111, 3'b011, 3'b010, 3'b111};
    else         ref_q = '{3'b011, 3'b101, 3'b111};
    check_obs("t2_seq");
    // No gap between frames: second frame's first bit follows the last tail load.
    check("t2_span", obs_cyc[obs_cyc.size()-1] - obs_cyc[0], ref_q.size() - 1);

    // Test 3: backpressure after first symbol of frame 1,0,1
    @(posedge clk);
    #1;
    clear_obs();
    send_bit(1'b1, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_bit    = 1'b0;
    in_last   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_hold_valid", out_valid, 1);
      check("t3_hold_sym", out_sym, 2'b11);
      check("t3_hold_last", out_last, 0);
      check("t3_in_ready", in_ready, 0);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    drain();
    if (TAIL_ON) ref_q = '{3'b011, 3'b010, 3'b000, 3'b010, 3'b111};
    else         ref_q = '{3'b011, 3'b010, 3'b100};
    check_obs("t3_seq");

    // Test 4: reset during the first tail cycle
    @(posedge clk);
    #1;
    send_bit(1'b1, 1'b0);
    send_bit(1'b0, 1'b0);
    send_bit(1'b1, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("t4_out_valid", out_valid, 0);
    check("t4_busy", busy, 0);
    check("t4_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    clear_obs();
    send_bit(1'b1, 1'b1);
    drain();
    if (TAIL_ON) ref_q = '{3'b011, 3'b010, 3'b111};
    else         ref_q = '{3'b111};
    check_obs("t4_seq");

    // Test 5: random 16-bit frame with alternating out_ready
    @(posedge clk);
    #1;
    clear_obs();
    last_cnt = 0;
    fork
      begin
        for (int i = 0; i < 16; i++) begin
          send_bit(1'($urandom_range(0, 1)), (i == 15));
        end
        drain();
        t5_done = 1'b1;
      end
      begin
        while (!t5_done) begin
          @(posedge clk);
          #1;
          out_ready = ~out_ready;
        end
      end
    join
    out_ready = 1'b1;
    check("t5_count", obs_q.size(), TAIL_ON ? 18 : 16);
    check("t5_last_cnt", last_cnt, 1);
    check("t5_final_last", obs_q[obs_q.size()-1][2], 1);
    @(negedge clk);
    check("t5_busy_end", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
